stopwatch_counter: RTL and testbench

- Downstream consumer of the run/pause control stage: counts the gated 1 Hz pulse it produces.
- Keeps elapsed time as four BCD digits, MM:SS, from 00:00 to 59:59.
- Either wraps or saturates at 59:59.
- Optionally drives a multiplexed four-digit seven-segment display.

---
 rtl/stopwatch_counter.sv | 159 +++++++++++++++
 tb/tb_stopwatch_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD elapsed-time counter (00:00 .. 59:59) driven by
// the gated 1 Hz level from the run/pause stage. A rising edge of pulse_in is
// one tick. WRAP selects wrap-around (with a one-cycle wrap pulse) or
// saturation at 59:59.
// Optional feature macro: STOPWATCH_SEVSEG_EN adds a multiplexed four-digit
// active-low seven-segment driver (seg/an ports and a SCAN_BITS scan counter).
module stopwatch_counter #(
  parameter int WRAP      = 1,
  parameter int SCAN_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       wrap,
  output logic       at_max
`ifdef STOPWATCH_SEVSEG_EN
  ,
  output logic [6:0] seg,
  output logic [3:0] an
`endif
);

  logic       pulse_q;
  logic       tick;
  logic [3:0] so_q, so_d;
  logic [2:0] st_q, st_d;
  logic [3:0] mo_q, mo_d;
  logic [2:0] mt_q, mt_d;
  logic       wrap_q, wrap_d;

  assign tick   = pulse_in & ~pulse_q;
  assign at_max = (mt_q == 3'd5) && (mo_q == 4'd9) && (st_q == 3'd5) && (so_q == 4'd9);

  // Next-state: clear beats tick; BCD ripple with wrap or saturate at 59:59.
  always_comb begin
    so_d   = so_q;
    st_d   = st_q;
    mo_d   = mo_q;
    mt_d   = mt_q;
    wrap_d = 1'b0;
    if (clear) begin
      so_d = 4'd0;
      st_d = 3'd0;
      mo_d = 4'd0;
      mt_d = 3'd0;
    end else if (tick) begin
      if (at_max) begin
        // Saturating build simply keeps 59:59 and drops the tick.
        if (WRAP != 0) begin
          so_d   = 4'd0;
          st_d   = 3'd0;
          mo_d   = 4'd0;
          mt_d   = 3'd0;
          wrap_d = 1'b1;
        end
      end else if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = 4'd0;
        if (st_q != 3'd5) begin
          st_d = st_q + 3'd1;
        end else begin
          st_d = 3'd0;
          if (mo_q != 4'd9) begin
            mo_d = mo_q + 4'd1;
          end else begin
            // min_tens < 5 here, otherwise at_max would have been taken.
            mo_d = 4'd0;
            mt_d = mt_q + 3'd1;
          end
        end
      end
    end
  end

  // Digit, wrap and edge-detect registers; pulse history updates even during clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= 1'b0;
      so_q    <= 4'd0;
      st_q    <= 3'd0;
      mo_q    <= 4'd0;
      mt_q    <= 3'd0;
      wrap_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_in;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign wrap     = wrap_q;

`ifdef STOPWATCH_SEVSEG_EN
  logic [SCAN_BITS-1:0] scan_q;
  logic [3:0]           digit_sel;
  logic [3:0]           an_d;
  logic [6:0]           seg_q;
  logic [3:0]           an_q;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Digit select from the top two scan-counter bits.
  always_comb begin
    digit_sel = so_q;
    an_d      = 4'b1110;
    case (scan_q[SCAN_BITS-1 -: 2])
      2'b00: begin digit_sel = so_q;         an_d = 4'b1110; end
      2'b01: begin digit_sel = {1'b0, st_q}; an_d = 4'b1101; end
      2'b10: begin digit_sel = mo_q;         an_d = 4'b1011; end
      default: begin digit_sel = {1'b0, mt_q}; an_d = 4'b0111; end
    endcase
  end

  // Free-running scan counter and registered display outputs; clear has no effect here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      seg_q  <= 7'b1000000;
      an_q   <= 4'b1110;
    end else begin
      scan_q <= scan_q + 1'b1;
      seg_q  <= seg_decode(digit_sel);
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Testbench for stopwatch_counter: a wrapping instance (SCAN_BITS=4) and a
// saturating instance share the same stimulus. Expected states are queued by
// the stimulus process and checked by an independent monitor on the falling edge.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in;
  logic       clear;

  logic [3:0] so_w, mo_w, so_s, mo_s;
  logic [2:0] st_w, mt_w, st_s, mt_s;
  logic       wrap_w, max_w, wrap_s, max_s;
`ifdef STOPWATCH_SEVSEG_EN
  logic [6:0] seg_w, seg_s;
  logic [3:0] an_w, an_s;
`endif

  stopwatch_counter #(.WRAP(1), .SCAN_BITS(4)) dut_w (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
    .sec_ones(so_w), .sec_tens(st_w), .min_ones(mo_w), .min_tens(mt_w),
    .wrap(wrap_w), .at_max(max_w)
`ifdef STOPWATCH_SEVSEG_EN
    , .seg(seg_w), .an(an_w)
`endif
  );

  stopwatch_counter #(.WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
    .sec_ones(so_s), .sec_tens(st_s), .min_ones(mo_s), .min_tens(mt_s),
    .wrap(wrap_s), .at_max(max_s)
`ifdef STOPWATCH_SEVSEG_EN
    , .seg(seg_s), .an(an_s)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference count of clock edges since reset release (scan phase model).
  int mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= 0;
    else      mcnt <= mcnt + 1;
  end

  typedef struct {
    int          due;
    string       name;
    int          kind;   // 0: digits/wrap/at_max, 1: seg/an
    bit          sat;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected {min_tens,min_ones,sec_tens,sec_ones,wrap,at_max} for the current cycle.
  task automatic chk(input string n, input bit sat, input int mm, input int ss,
                     input bit wr, input bit mx);
    exp_t e;
    e.due  = cyc;
    e.name = n;
    e.kind = 0;
    e.sat  = sat;
    e.val  = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), wr, mx};
    sb.push_back(e);
  endtask

  task automatic chk2(input string n, input int mm, input int ss, input bit wr, input bit mx);
    chk(n, 1'b0, mm, ss, wr, mx);
    chk(n, 1'b1, mm, ss, wr, mx);
  endtask

  task automatic chk_seg(input string n, input logic [6:0] sg, input logic [3:0] a);
    exp_t e;
    e.due  = cyc;
    e.name = n;
    e.kind = 1;
    e.sat  = 1'b0;
    e.val  = {5'd0, sg, a};
    sb.push_back(e);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      step(hi);
      pulse_in = 1'b0;
      step(lo);
    end
  endtask

  // Monitor: pops every queued expectation that falls due and compares it.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        act = 16'h0;
        if (e.kind == 0) begin
          act = e.sat ? {mt_s, mo_s, st_s, so_s, wrap_s, max_s}
                      : {mt_w, mo_w, st_w, so_w, wrap_w, max_w};
        end
`ifdef STOPWATCH_SEVSEG_EN
        else begin
          act = {5'd0, seg_w, an_w};
        end
`endif
        if (e.due != cyc) begin
          n_fail++;
          $display("FAIL %s: check missed its cycle, got cycle %0d, required %0d", e.name, cyc, e.due);
        end else if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s (%s): got %h, required %h", e.name,
                   (e.kind == 1) ? "seg/an" : (e.sat ? "sat" : "wrap"), act, e.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] seg_tab [4];
    logic [3:0] an_tab  [4];
    int         sel;
    seg_tab = '{7'b1111000, 7'b0110000, 7'b0010010, 7'b1000000};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst      = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    step(2);
    chk2("reset_state", 0, 0, 0, 0);
`ifdef STOPWATCH_SEVSEG_EN
    chk_seg("reset_display", 7'b1000000, 4'b1110);
`endif
    rst = 1'b1;
    step(2);

    // Counting with 2-high / 5-low pulses, including the 59 -> 1:00 carry.
    pulses(1, 2, 5);
    chk2("count_1", 0, 1, 0, 0);
    pulses(9, 2, 5);
    chk2("count_10", 0, 10, 0, 0);
    pulses(49, 2, 5);
    chk2("count_59", 0, 59, 0, 0);
    pulse_in = 1'b1;
    step(1);
    chk2("count_60_carry", 1, 0, 0, 0);
    pulse_in = 1'b0;
    step(5);

    // Clear, then a long high level gives exactly one tick.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk2("clear", 0, 0, 0, 0);
    pulse_in = 1'b1;
    step(1);
    chk2("long_high_first", 0, 1, 0, 0);
    step(99);
    chk2("long_high_held", 0, 1, 0, 0);
    pulse_in = 1'b0;
    step(1);
    chk2("long_high_release", 0, 1, 0, 0);

    // Asynchronous reset mid-count at 12:34.
    pulses(753, 1, 1);
    chk2("at_12_34", 12, 34, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk2("async_reset", 0, 0, 0, 0);
`ifdef STOPWATCH_SEVSEG_EN
    chk_seg("async_reset_display", 7'b1000000, 4'b1110);
`endif
    step(1);
    rst = 1'b1;
    step(1);

    // Climb to 59:59, then one more pulse: wrap vs saturate.
    pulses(3599, 1, 1);
    chk2("at_59_59", 59, 59, 0, 1);
    pulse_in = 1'b1;
    step(1);
    chk("wrap_edge", 1'b0, 0, 0, 1, 0);
    chk("sat_edge", 1'b1, 59, 59, 0, 1);
    pulse_in = 1'b0;
    step(1);
    chk("wrap_pulse_ends", 1'b0, 0, 0, 0, 0);
    chk("sat_holds", 1'b1, 59, 59, 0, 1);
    step(1);

    // Clear colliding with a tick at 00:07.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    pulses(7, 1, 1);
    chk2("at_00_07", 0, 7, 0, 0);
    clear    = 1'b1;
    pulse_in = 1'b1;
    step(1);
    chk2("clear_beats_tick", 0, 0, 0, 0);
    clear = 1'b0;
    step(3);
    chk2("held_after_clear", 0, 0, 0, 0);
    pulse_in = 1'b0;
    step(1);
    pulse_in = 1'b1;
    step(1);
    chk2("tick_after_clear", 0, 1, 0, 0);
    pulse_in = 1'b0;
    step(1);

`ifdef STOPWATCH_SEVSEG_EN
    // Display scan of 05:37.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    pulses(337, 1, 1);
    chk2("at_05_37", 5, 37, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      sel = ((mcnt - 1) % 16) / 4;
      chk_seg("scan", seg_tab[sel], an_tab[sel]);
    end
`endif

    // pulse_in already high when reset releases counts as a tick.
    @(posedge clk);
    #1;
    rst      = 1'b0;
    pulse_in = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    chk2("high_at_release", 0, 1, 0, 0);
    pulse_in = 1'b0;
    step(3);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
